branch_resolver: RTL and testbench
==================================

BRANCH_RESOLVER -- requirements
Module: branch_resolver

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, meaning PC/target width.
REQ-002 SHALL have parameter DEPTH, default 4, meaning in-flight prediction queue entries; power of two, ≥2.
REQ-003 SHALL have parameter CNT_WIDTH, default 32, meaning statistics counter width.
REQ-004 SHALL have port clk input 1, meaning the single clock; all logic on posedge.
REQ-005 SHALL have port rstn input 1, meaning reset; synchronous, active-high (rstn=1 resets).
REQ-006 SHALL have port push_valid input 1, meaning fetch issues a branch prediction record.
REQ-007 SHALL have port push_pc input DATA_WIDTH, meaning the fetched branch PC.
REQ-008 SHALL have ports push_hit, push_pred input 1 each, meaning BTB hit and direction prediction.
REQ-009 SHALL have port push_target input DATA_WIDTH, meaning the BTB target.
REQ-010 SHALL have port push_ready output 1, meaning queue not full.
REQ-011 SHALL have ports res_valid, res_taken input 1 each, meaning an in-order resolution and its actual outcome.
REQ-012 SHALL have port res_target input DATA_WIDTH, meaning the actual target.
REQ-013 SHALL have port ext_flush input 1, meaning a pipeline flush from another source.
REQ-014 SHALL have ports update_predictor, update_btb, actually_taken output 1 each, meaning predictor/BTB update strobes and outcome.
REQ-015 SHALL have ports resolved_pc, resolved_pc_target output DATA_WIDTH, meaning update PC and target.
REQ-016 SHALL have ports mispredict output 1 and redirect_pc output DATA_WIDTH, meaning fetch redirect pulse and address.
REQ-017 SHALL have ports empty output 1, count output $clog2(DEPTH)+1, underflow_err output 1 (sticky).

Function
REQ-018 SHALL accept a push when push_valid && push_ready; push_ready = (count != DEPTH), from registered state only.
REQ-019 SHALL pop the oldest entry on res_valid when !empty; res_valid with empty queue SHALL be ignored and SHALL set underflow_err.
REQ-020 SHALL treat effective prediction as taken = hit && pred, predicted next PC = taken ? target : pc+4 (modulo 2^DATA_WIDTH).
REQ-021 SHALL flag mispredict when res_taken != effective taken, or both taken and res_target != stored target.
REQ-022 SHALL, one cycle after a pop, pulse update_predictor=1, update_btb=res_taken, actually_taken=res_taken, resolved_pc=stored pc, resolved_pc_target=res_target.
REQ-023 SHALL, in the same cycle as REQ-022, pulse mispredict on a mispredict, with redirect_pc = res_taken ? res_target : pc+4; otherwise mispredict=0.
REQ-024 SHALL, on a mispredicting pop, clear the queue (count=0, pointers reset) at the same clock edge; a push in that cycle SHALL be dropped.
REQ-025 SHALL, on ext_flush, clear the queue identically; ext_flush with simultaneous res_valid SHALL still perform the pop and REQ-022/023 outputs.
REQ-026 SHALL on simultaneous push and non-mispredicting pop update both; count unchanged.
REQ-027 SHALL hold pulse outputs at 0 and data outputs at last value in non-pop cycles; pointers wrap modulo DEPTH.

Reset
REQ-028 SHALL on rstn=1 set count=0, pointers=0, empty=1, underflow_err=0, all strobes and mispredict=0, resolved_pc, resolved_pc_target, redirect_pc=0, counters=0.
REQ-029 SHALL give reset priority over push, pop and flush; reset mid-operation discards all entries.

Configuration
REQ-030 SHALL, with BRANCH_STATS_EN defined, provide outputs stat_branches and stat_mispredicts (CNT_WIDTH) counting pops and mispredicts, saturating at all-ones.
REQ-031 SHALL, without BRANCH_STATS_EN, omit those ports and counters entirely.

Structure
REQ-032 SHALL place the prediction-record typedef (pc, hit, pred, target) and the PC increment constant 4 in shared package branch_pkg.
REQ-033 SHALL implement storage as one sub-module pred_queue (synchronous FIFO with clear); compare/redirect logic in branch_resolver.

Verification
REQ-034 Push {pc=0x100,hit=1,pred=1,tgt=0x200}; resolve taken,0x200 -> next cycle update_predictor=1, update_btb=1, resolved_pc=0x100, mispredict=0.
REQ-035 Push {0x104,hit=0}; resolve taken,0x300 -> mispredict=1, redirect_pc=0x300, queue cleared (empty=1).
REQ-036 Push {0x108,1,1,0x400}; resolve taken,0x500 -> mispredict=1, redirect_pc=0x500; resolve not-taken -> redirect_pc=0x10C.
REQ-037 Push 4 entries (DEPTH=4) -> push_ready=0, fifth push dropped; pop+push same cycle -> count stays 4.
REQ-038 res_valid with empty queue -> no strobes, underflow_err=1 until reset; ext_flush with 3 entries -> count=0 next cycle.
REQ-039 With BRANCH_STATS_EN and CNT_WIDTH=2, 5 mispredicting pops -> stat_mispredicts saturates at 3.

Source files
------------

// File: rtl/branch_pkg.sv
// Shared types and constants for the branch resolver slice.
package branch_pkg;

  localparam int unsigned PC_MAX_WIDTH = 64;
  localparam int unsigned PC_INC       = 4;

  // Fields are sized for the widest supported PC; narrower builds zero-extend.
  typedef struct packed {
    logic [PC_MAX_WIDTH-1:0] pc;
    logic                    hit;
    logic                    pred;
    logic [PC_MAX_WIDTH-1:0] target;
  } pred_rec_t;

endpackage

// File: rtl/pred_queue.sv
// In-flight prediction queue: synchronous FIFO with a clear that overrides push/pop.
module pred_queue
  import branch_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clear,
  input  logic                     push,
  input  logic                     pop,
  input  pred_rec_t                wr_data,
  output pred_rec_t                rd_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty,
  output logic                     full
);

  localparam int unsigned AW = $clog2(DEPTH);

  pred_rec_t        mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(DEPTH));
  assign do_push = push && !full && !clear;
  assign do_pop  = pop && !empty;
  assign rd_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + {{AW{1'b0}}, do_push} - {{AW{1'b0}}, do_pop};
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wr_data;
  end

endmodule

// File: rtl/branch_resolver.sv
// Compares in-order branch resolutions against queued predictions and drives
// predictor/BTB updates and fetch redirects. Optional counters: BRANCH_STATS_EN.
module branch_resolver
  import branch_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned DEPTH      = 4,
  parameter int unsigned CNT_WIDTH  = 32
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic                    push_valid,
  input  logic [DATA_WIDTH-1:0]   push_pc,
  input  logic                    push_hit,
  input  logic                    push_pred,
  input  logic [DATA_WIDTH-1:0]   push_target,
  output logic                    push_ready,
  input  logic                    res_valid,
  input  logic                    res_taken,
  input  logic [DATA_WIDTH-1:0]   res_target,
  input  logic                    ext_flush,
  output logic                    update_predictor,
  output logic                    update_btb,
  output logic                    actually_taken,
  output logic [DATA_WIDTH-1:0]   resolved_pc,
  output logic [DATA_WIDTH-1:0]   resolved_pc_target,
  output logic                    mispredict,
  output logic [DATA_WIDTH-1:0]   redirect_pc,
  output logic                    empty,
  output logic [$clog2(DEPTH):0]  count,
  output logic                    underflow_err
`ifdef BRANCH_STATS_EN
  ,
  output logic [CNT_WIDTH-1:0]    stat_branches,
  output logic [CNT_WIDTH-1:0]    stat_mispredicts
`endif
);

  pred_rec_t               push_rec;
  pred_rec_t               head;
  logic                    full;
  logic                    pop;
  logic                    eff_taken;
  logic                    mis;
  logic                    clear;
  logic [DATA_WIDTH-1:0]   head_pc;
  logic [DATA_WIDTH-1:0]   head_tgt;
  logic [DATA_WIDTH-1:0]   head_pc_inc;

  always_comb begin
    push_rec        = '0;
    push_rec.pc     = PC_MAX_WIDTH'(push_pc);
    push_rec.hit    = push_hit;
    push_rec.pred   = push_pred;
    push_rec.target = PC_MAX_WIDTH'(push_target);
  end

  pred_queue #(.DEPTH(DEPTH)) u_queue (
    .clk     (clk),
    .rst     (rstn),
    .clear   (clear),
    .push    (push_valid),
    .pop     (pop),
    .wr_data (push_rec),
    .rd_data (head),
    .count   (count),
    .empty   (empty),
    .full    (full)
  );

  assign push_ready  = !full;
  assign pop         = res_valid && !empty;
  assign head_pc     = head.pc[DATA_WIDTH-1:0];
  assign head_tgt    = head.target[DATA_WIDTH-1:0];
  assign head_pc_inc = head_pc + DATA_WIDTH'(PC_INC);
  assign eff_taken   = head.hit && head.pred;
  assign mis         = (res_taken != eff_taken) || (res_taken && (res_target != head_tgt));
  // A flush still lets a concurrent pop report; the queue clear drops any same-cycle push.
  assign clear       = ext_flush || (pop && mis);

  always_ff @(posedge clk) begin
    if (rstn) begin
      update_predictor   <= 1'b0;
      update_btb         <= 1'b0;
      actually_taken     <= 1'b0;
      mispredict         <= 1'b0;
      resolved_pc        <= '0;
      resolved_pc_target <= '0;
      redirect_pc        <= '0;
      underflow_err      <= 1'b0;
    end else begin
      update_predictor <= pop;
      update_btb       <= pop && res_taken;
      actually_taken   <= pop && res_taken;
      mispredict       <= pop && mis;
      if (pop) begin
        resolved_pc        <= head_pc;
        resolved_pc_target <= res_target;
        redirect_pc        <= res_taken ? res_target : head_pc_inc;
      end
      if (res_valid && empty) underflow_err <= 1'b1;
    end
  end

`ifdef BRANCH_STATS_EN
  always_ff @(posedge clk) begin
    if (rstn) begin
      stat_branches    <= '0;
      stat_mispredicts <= '0;
    end else begin
      if (pop && (stat_branches != '1))           stat_branches    <= stat_branches + 1'b1;
      if (pop && mis && (stat_mispredicts != '1)) stat_mispredicts <= stat_mispredicts + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_branch_resolver.sv
// Directed self-checking bench for branch_resolver (DEPTH=4, CNT_WIDTH=2).
module tb_branch_resolver;

  logic        clk = 1'b0;
  logic        rstn;
  logic        push_valid;
  logic [31:0] push_pc;
  logic        push_hit;
  logic        push_pred;
  logic [31:0] push_target;
  logic        push_ready;
  logic        res_valid;
  logic        res_taken;
  logic [31:0] res_target;
  logic        ext_flush;
  logic        update_predictor;
  logic        update_btb;
  logic        actually_taken;
  logic [31:0] resolved_pc;
  logic [31:0] resolved_pc_target;
  logic        mispredict;
  logic [31:0] redirect_pc;
  logic        empty;
  logic [2:0]  count;
  logic        underflow_err;
`ifdef BRANCH_STATS_EN
  logic [1:0]  stat_branches;
  logic [1:0]  stat_mispredicts;
`endif

  int compared = 0;
  int mismatched = 0;

  always #5 clk = ~clk;

  branch_resolver #(.DATA_WIDTH(32), .DEPTH(4), .CNT_WIDTH(2)) dut (
    .clk                (clk),
    .rstn               (rstn),
    .push_valid         (push_valid),
    .push_pc            (push_pc),
    .push_hit           (push_hit),
    .push_pred          (push_pred),
    .push_target        (push_target),
    .push_ready         (push_ready),
    .res_valid          (res_valid),
    .res_taken          (res_taken),
    .res_target         (res_target),
    .ext_flush          (ext_flush),
    .update_predictor   (update_predictor),
    .update_btb         (update_btb),
    .actually_taken     (actually_taken),
    .resolved_pc        (resolved_pc),
    .resolved_pc_target (resolved_pc_target),
    .mispredict         (mispredict),
    .redirect_pc        (redirect_pc),
    .empty              (empty),
    .count              (count),
    .underflow_err      (underflow_err)
`ifdef BRANCH_STATS_EN
    ,
    .stat_branches      (stat_branches),
    .stat_mispredicts   (stat_mispredicts)
`endif
  );

  // One clock cycle of stimulus; returns 1ns after the edge so registered results are visible.
  task automatic cyc(input logic pv, input logic [31:0] pc, input logic h, input logic p,
                     input logic [31:0] tg, input logic rv, input logic rt,
                     input logic [31:0] rtg, input logic fl);
    @(negedge clk);
    push_valid = pv; push_pc = pc; push_hit = h; push_pred = p; push_target = tg;
    res_valid = rv; res_taken = rt; res_target = rtg; ext_flush = fl;
    @(posedge clk);
    #1;
    push_valid = 1'b0; res_valid = 1'b0; ext_flush = 1'b0;
  endtask

  task automatic push(input logic [31:0] pc, input logic h, input logic p, input logic [31:0] tg);
    cyc(1'b1, pc, h, p, tg, 1'b0, 1'b0, 32'h0, 1'b0);
  endtask

  task automatic resolve(input logic rt, input logic [31:0] rtg);
    cyc(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b1, rt, rtg, 1'b0);
  endtask

  task automatic idle();
    cyc(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rstn = 1'b1;
    @(posedge clk); @(posedge clk);
    #1;
    rstn = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    compared++; if (count !== 3'd0) begin mismatched++; $display("FAIL reset_count got %0d want 0", count); end
    compared++; if (empty !== 1'b1) begin mismatched++; $display("FAIL reset_empty got %b want 1", empty); end
    compared++; if (push_ready !== 1'b1) begin mismatched++; $display("FAIL reset_ready got %b want 1", push_ready); end
    compared++; if (underflow_err !== 1'b0) begin mismatched++; $display("FAIL reset_uflow got %b want 0", underflow_err); end
    compared++; if ({update_predictor, update_btb, actually_taken, mispredict} !== 4'b0) begin
      mismatched++; $display("FAIL reset_strobes got %b want 0000", {update_predictor, update_btb, actually_taken, mispredict}); end
    compared++; if ({resolved_pc, resolved_pc_target, redirect_pc} !== 96'h0) begin
      mismatched++; $display("FAIL reset_data got %h %h %h want 0", resolved_pc, resolved_pc_target, redirect_pc); end
  endtask

  task automatic test_correct_taken();
    push(32'h100, 1'b1, 1'b1, 32'h200);
    compared++; if (count !== 3'd1) begin mismatched++; $display("FAIL ct_count got %0d want 1", count); end
    resolve(1'b1, 32'h200);
    compared++; if ({update_predictor, update_btb, actually_taken, mispredict} !== 4'b1110) begin
      mismatched++; $display("FAIL ct_strobes got %b want 1110", {update_predictor, update_btb, actually_taken, mispredict}); end
    compared++; if (resolved_pc !== 32'h100) begin mismatched++; $display("FAIL ct_pc got %h want 100", resolved_pc); end
    compared++; if (resolved_pc_target !== 32'h200) begin mismatched++; $display("FAIL ct_tgt got %h want 200", resolved_pc_target); end
    compared++; if (empty !== 1'b1) begin mismatched++; $display("FAIL ct_empty got %b want 1", empty); end
    idle();
    compared++; if ({update_predictor, update_btb, mispredict} !== 3'b0) begin
      mismatched++; $display("FAIL ct_idle_strobes got %b want 000", {update_predictor, update_btb, mispredict}); end
    compared++; if (resolved_pc !== 32'h100) begin mismatched++; $display("FAIL ct_hold_pc got %h want 100", resolved_pc); end
  endtask

  task automatic test_mispredict_dir();
    push(32'h104, 1'b0, 1'b0, 32'h0);
    push(32'h180, 1'b1, 1'b1, 32'h1C0);
    // mispredicting pop with a concurrent push: both queued entries and the push are dropped
    cyc(1'b1, 32'h999, 1'b1, 1'b1, 32'h777, 1'b1, 1'b1, 32'h300, 1'b0);
    compared++; if (mispredict !== 1'b1) begin mismatched++; $display("FAIL md_mis got %b want 1", mispredict); end
    compared++; if (redirect_pc !== 32'h300) begin mismatched++; $display("FAIL md_redirect got %h want 300", redirect_pc); end
    compared++; if (resolved_pc !== 32'h104) begin mismatched++; $display("FAIL md_pc got %h want 104", resolved_pc); end
    compared++; if (count !== 3'd0 || empty !== 1'b1) begin mismatched++; $display("FAIL md_cleared got count=%0d empty=%b want 0 1", count, empty); end
    idle();
    compared++; if (mispredict !== 1'b0) begin mismatched++; $display("FAIL md_pulse got %b want 0", mispredict); end
  endtask

  task automatic test_mispredict_target();
    push(32'h108, 1'b1, 1'b1, 32'h400);
    resolve(1'b1, 32'h500);
    compared++; if (mispredict !== 1'b1 || redirect_pc !== 32'h500) begin
      mismatched++; $display("FAIL mt_tgt got mis=%b pc=%h want 1 500", mispredict, redirect_pc); end
    push(32'h108, 1'b1, 1'b1, 32'h400);
    resolve(1'b0, 32'h0);
    compared++; if (mispredict !== 1'b1 || redirect_pc !== 32'h10C) begin
      mismatched++; $display("FAIL mt_nt got mis=%b pc=%h want 1 10c", mispredict, redirect_pc); end
    compared++; if ({update_predictor, update_btb, actually_taken} !== 3'b100) begin
      mismatched++; $display("FAIL mt_nt_strobes got %b want 100", {update_predictor, update_btb, actually_taken}); end
    push(32'hFFFF_FFFC, 1'b1, 1'b1, 32'h10);
    resolve(1'b0, 32'h0);
    compared++; if (mispredict !== 1'b1 || redirect_pc !== 32'h0) begin
      mismatched++; $display("FAIL mt_wrap got mis=%b pc=%h want 1 0", mispredict, redirect_pc); end
    push(32'h200, 1'b0, 1'b1, 32'h0);
    resolve(1'b0, 32'h0);
    compared++; if (mispredict !== 1'b0 || update_predictor !== 1'b1) begin
      mismatched++; $display("FAIL mt_nohit_nt got mis=%b upd=%b want 0 1", mispredict, update_predictor); end
  endtask

  task automatic test_full_and_back_to_back();
    logic [31:0] exp_pcs [4];
    exp_pcs[0] = 32'h18; exp_pcs[1] = 32'h1C; exp_pcs[2] = 32'h24; exp_pcs[3] = 32'h28;
    for (int i = 0; i < 4; i++) push(32'h10 + 32'(4 * i), 1'b1, 1'b1, 32'h50 + 32'(4 * i));
    compared++; if (count !== 3'd4 || push_ready !== 1'b0) begin
      mismatched++; $display("FAIL full got count=%0d ready=%b want 4 0", count, push_ready); end
    push(32'h20, 1'b1, 1'b1, 32'h60);
    compared++; if (count !== 3'd4) begin mismatched++; $display("FAIL full_drop got %0d want 4", count); end
    resolve(1'b1, 32'h50);
    compared++; if (resolved_pc !== 32'h10 || count !== 3'd3 || push_ready !== 1'b1) begin
      mismatched++; $display("FAIL full_pop got pc=%h count=%0d ready=%b want 10 3 1", resolved_pc, count, push_ready); end
    cyc(1'b1, 32'h24, 1'b1, 1'b1, 32'h64, 1'b1, 1'b1, 32'h54, 1'b0);
    compared++; if (resolved_pc !== 32'h14 || count !== 3'd3 || mispredict !== 1'b0) begin
      mismatched++; $display("FAIL b2b got pc=%h count=%0d mis=%b want 14 3 0", resolved_pc, count, mispredict); end
    push(32'h28, 1'b1, 1'b1, 32'h68);
    compared++; if (count !== 3'd4) begin mismatched++; $display("FAIL b2b_refill got %0d want 4", count); end
    for (int i = 0; i < 4; i++) begin
      resolve(1'b1, exp_pcs[i] + 32'h40);
      compared++; if (resolved_pc !== exp_pcs[i] || mispredict !== 1'b0) begin
        mismatched++; $display("FAIL drain%0d got pc=%h mis=%b want %h 0", i, resolved_pc, mispredict, exp_pcs[i]); end
    end
    compared++; if (empty !== 1'b1) begin mismatched++; $display("FAIL drain_empty got %b want 1", empty); end
  endtask

  task automatic test_underflow_flush();
    resolve(1'b1, 32'h123);
    compared++; if (update_predictor !== 1'b0 || mispredict !== 1'b0 || underflow_err !== 1'b1) begin
      mismatched++; $display("FAIL uflow got upd=%b mis=%b err=%b want 0 0 1", update_predictor, mispredict, underflow_err); end
    idle();
    compared++; if (underflow_err !== 1'b1) begin mismatched++; $display("FAIL uflow_sticky got %b want 1", underflow_err); end
    for (int i = 0; i < 3; i++) push(32'h500 + 32'(4 * i), 1'b0, 1'b0, 32'h0);
    compared++; if (count !== 3'd3) begin mismatched++; $display("FAIL fl_fill got %0d want 3", count); end
    cyc(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b1);
    compared++; if (count !== 3'd0 || empty !== 1'b1 || update_predictor !== 1'b0) begin
      mismatched++; $display("FAIL flush got count=%0d empty=%b upd=%b want 0 1 0", count, empty, update_predictor); end
    push(32'h300, 1'b1, 1'b1, 32'h380);
    push(32'h304, 1'b1, 1'b1, 32'h390);
    cyc(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 32'h380, 1'b1);
    compared++; if (update_predictor !== 1'b1 || resolved_pc !== 32'h300 || mispredict !== 1'b0 || count !== 3'd0) begin
      mismatched++; $display("FAIL flush_pop got upd=%b pc=%h mis=%b count=%0d want 1 300 0 0",
                             update_predictor, resolved_pc, mispredict, count); end
  endtask

  task automatic test_reset_mid_op();
    push(32'h600, 1'b1, 1'b1, 32'h700);
    push(32'h604, 1'b1, 1'b1, 32'h704);
    @(negedge clk);
    rstn = 1'b1; push_valid = 1'b1; push_pc = 32'h608; res_valid = 1'b1; res_taken = 1'b0;
    @(posedge clk);
    #1;
    rstn = 1'b0; push_valid = 1'b0; res_valid = 1'b0;
    compared++; if (count !== 3'd0 || update_predictor !== 1'b0 || mispredict !== 1'b0 || underflow_err !== 1'b0) begin
      mismatched++; $display("FAIL rst_mid got count=%0d upd=%b mis=%b err=%b want 0 0 0 0",
                             count, update_predictor, mispredict, underflow_err); end
    compared++; if (resolved_pc !== 32'h0 || redirect_pc !== 32'h0) begin
      mismatched++; $display("FAIL rst_mid_data got %h %h want 0 0", resolved_pc, redirect_pc); end
  endtask

`ifdef BRANCH_STATS_EN
  task automatic test_stats();
    do_reset();
    compared++; if (stat_branches !== 2'd0 || stat_mispredicts !== 2'd0) begin
      mismatched++; $display("FAIL stat_reset got %0d %0d want 0 0", stat_branches, stat_mispredicts); end
    for (int i = 0; i < 5; i++) begin
      push(32'h40, 1'b0, 1'b0, 32'h0);
      resolve(1'b1, 32'h300);
    end
    compared++; if (stat_mispredicts !== 2'd3 || stat_branches !== 2'd3) begin
      mismatched++; $display("FAIL stat_sat got br=%0d mis=%0d want 3 3", stat_branches, stat_mispredicts); end
  endtask
`endif

  initial begin
    rstn = 1'b1; push_valid = 1'b0; push_pc = '0; push_hit = 1'b0; push_pred = 1'b0; push_target = '0;
    res_valid = 1'b0; res_taken = 1'b0; res_target = '0; ext_flush = 1'b0;
    test_reset();
    test_correct_taken();
    test_mispredict_dir();
    test_mispredict_target();
    test_full_and_back_to_back();
    test_underflow_flush();
    test_reset_mid_op();
`ifdef BRANCH_STATS_EN
    test_stats();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got running want finished");
    $fatal(1);
  end

endmodule
